uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal TX FIFO, runtime baud divisor and a programmable frame format.
Parameters set data width (5-9 bits) and FIFO depth.
Frames are sent back-to-back with no idle gap while the FIFO is non-empty, and the block can also generate a line break.
It sits between a bus-side producer and the serial pad, next to the existing UART receive path.

Parameters:
P_DATA_W, 8, data bits per frame; legal 5..9.
P_FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2.
P_DIV_W, 16, width of the baud divisor input.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_n_i  in  1  asynchronous, active-low reset.
wr_en_i  in  1  push wr_data_i into the FIFO.
wr_data_i  in  P_DATA_W  word to transmit.
full_o  out  1  FIFO full.
empty_o  out  1  FIFO empty.
level_o  out  clog2(P_FIFO_DEPTH)+1  FIFO occupancy.
overflow_o  out  1  one-cycle pulse: a write was dropped.
div_i  in  P_DIV_W  clock cycles per bit; values below 2 are treated as 2.
parity_en_i  in  1  insert a parity bit.
parity_sel_i  in  1  1 = even parity, 0 = odd parity.
stop_sel_i  in  1  0 = one stop bit, 1 = two stop bits.
break_i  in  1  request a break (line held low).
tx_o  out  1  serial line; registered; idle level high.
busy_o  out  1  state != IDLE.
frame_done_o  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset, asynchronous: state IDLE, tx_o=1, FIFO empty (level_o=0, empty_o=1, full_o=0), overflow_o=0, frame_done_o=0, all counters 0.
- Reset mid-frame aborts the frame immediately; queued data is discarded.
- FIFO write:
  - Accepted when wr_en_i=1 and full_o=0.
  - If full_o=1 in the write cycle, the word is dropped and overflow_o pulses on the next cycle. This holds even if a pop occurs in the same cycle.
  - A simultaneous write and pop leaves level_o unchanged.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- Leaving IDLE:
  - When break_i=1: go to BREAK; tx_o<=0 on the next edge; the FIFO is not popped.
  - Otherwise, when !empty_o: pop the head word at that edge and go to START; tx_o<=0.
  - In both cases, latch div (clamped), parity_en_i, parity_sel_i and stop_sel_i at the same edge.
  - Config input changes mid-frame have no effect.
- Bit timing:
  - Each bit holds tx_o for exactly div cycles. The cycle counter runs 0..div-1.
  - At count==div-1 the counter resets, the next bit value is registered onto tx_o and the state advances.
- Frame sequence: START (0), then DATA with P_DATA_W bits LSB first (bit index 0..P_DATA_W-1), then PARITY if enabled, then STOP (1) for 1 or 2 bit times.
- Parity is computed from the latched word:
  - Even: bit = XOR of the data bits (total count of ones, including parity, is even).
  - Odd: the inverse.
- End of the last stop bit:
  - frame_done_o pulses for 1 cycle.
  - If the FIFO is non-empty and break_i=0: pop, re-latch config, go directly to START. tx_o goes low on that same edge, so there is no idle cycle.
  - Otherwise go to IDLE with tx_o=1.
- Break is requested only from IDLE or at a frame boundary; a break_i rise mid-frame waits for the frame to end.
  - In BREAK, tx_o=0 while break_i=1.
  - On break_i=0: tx_o<=1 and go to IDLE. The minimum IDLE dwell after a break is 1 cycle.
  - FIFO writes are accepted during BREAK.
- Frame length in cycles: div*(1 + P_DATA_W + parity_en + 1 + stop_sel).
- busy_o is high in START, DATA, PARITY, STOP and BREAK.

Test Plan:
- Basic frame: P_DATA_W=8, div=4, parity off, 1 stop; write 0xA5 -> tx_o = 0 x4, then 1,0,1,0,0,1,0,1 each x4, then 1 x4. Frame is 40 cycles; frame_done_o pulses once; busy_o drops after.
- Parity and stop bits: write 0x07 with even parity -> parity bit 1. With odd parity -> parity bit 0. With stop_sel_i=1 -> 8 high cycles (div=4) before idle; frame is 48 cycles.
- FIFO fill/overflow: depth 4, div=8; six writes on consecutive cycles starting in IDLE -> first word popped the cycle after its write, level_o reaches 4, sixth write dropped with one overflow_o pulse. Five frames then go back-to-back with no high gap beyond the stop bits, data in write order.
- Break: FIFO empty, break_i high 20 cycles -> tx_o low 20 cycles, busy_o=1. A word written during the break starts its frame only after break_i falls and 1 IDLE cycle passes.
- Reset mid-frame: deassert rst_n_i during data bit 3 with 2 words queued -> tx_o=1 and level_o=0 immediately (no clock edge needed). After release, IDLE, no transmission.
- Divisor clamp and config latch: div_i=0 -> every bit lasts 2 cycles. Changing div_i to 6 mid-frame leaves the current frame at 2 cycles/bit; the next frame uses 6.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal TX FIFO, runtime baud divisor, programmable
// frame format (parity, 1/2 stop bits) and line-break generation.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word or a break request
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | optional parity bit
// STOP   | one or two stop bits (1)
// BREAK  | line held low while break_i stays high
module uart_tx_fifo #(
  parameter int P_DATA_W     = 8,
  parameter int P_FIFO_DEPTH = 4,
  parameter int P_DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          wr_en_i,
  input  logic [P_DATA_W-1:0]           wr_data_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(P_FIFO_DEPTH):0] level_o,
  output logic                          overflow_o,
  input  logic [P_DIV_W-1:0]            div_i,
  input  logic                          parity_en_i,
  input  logic                          parity_sel_i,
  input  logic                          stop_sel_i,
  input  logic                          break_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          frame_done_o
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(P_DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // ---------------- FIFO ----------------
  logic [P_DATA_W-1:0] mem_q [P_FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;
  logic                overflow_q;
  logic                push, pop;
  logic [P_DATA_W-1:0] head;

  assign full_o     = (level_q == LW'(P_FIFO_DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign push       = wr_en_i && !full_o;
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
      overflow_q <= wr_en_i && full_o;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------- transmit FSM ----------------
  state_t              state_q, state_d;
  logic [P_DIV_W-1:0]  cnt_q, cnt_d;
  logic [P_DIV_W-1:0]  div_q, div_d;
  logic [IW-1:0]       bit_q, bit_d;
  logic [P_DATA_W-1:0] sh_q, sh_d;
  logic                par_q, par_d;
  logic                par_en_q, par_en_d;
  logic                stop_sel_q, stop_sel_d;
  logic                stop2_q, stop2_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                tc, start_frame, latch_cfg;
  logic [P_DIV_W-1:0]  div_clamp;

  assign div_clamp = (div_i < P_DIV_W'(2)) ? P_DIV_W'(2) : div_i;
  assign tc        = (cnt_q == div_q - P_DIV_W'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    par_d       = par_q;
    par_en_d    = par_en_q;
    stop_sel_d  = stop_sel_q;
    stop2_d     = stop2_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    start_frame = 1'b0;
    latch_cfg   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (break_i) begin
          state_d   = S_BREAK;
          tx_d      = 1'b0;
          latch_cfg = 1'b1;
        end else if (!empty_o) begin
          start_frame = 1'b1;
        end
      end
      S_START: begin
        if (tc) begin
          state_d = S_DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tc) begin
          if (bit_q == IW'(P_DATA_W - 1)) begin
            stop2_d = 1'b0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + IW'(1);
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (tc) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          stop2_d = 1'b0;
        end
      end
      S_STOP: begin
        if (tc) begin
          if (stop_sel_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!empty_o && !break_i) begin
              start_frame = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end
        end
      end
      S_BREAK: begin
        if (!break_i) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (state_q != S_IDLE && state_q != S_BREAK) begin
      cnt_d = tc ? '0 : cnt_q + P_DIV_W'(1);
    end

    // Parity is fixed at pop time from the word and the parity select seen then.
    if (start_frame) begin
      pop       = 1'b1;
      latch_cfg = 1'b1;
      state_d   = S_START;
      tx_d      = 1'b0;
      sh_d      = head;
      par_d     = parity_sel_i ? ^head : ~^head;
    end

    if (latch_cfg) begin
      div_d      = div_clamp;
      par_en_d   = parity_en_i;
      stop_sel_d = stop_sel_i;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop_sel_q <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      stop_sel_q <= stop_sel_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = done_q;

endmodule
